invader_march_scheduler: RTL

INVADER_MARCH_SCHEDULER -- requirements
Module: invader_march_scheduler

---
 rtl/invader_march_scheduler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/invader_march_scheduler.sv
// Space-invader formation march scheduler: paces left/right steps and row drops
// from the live enemy count. Optional `MARCH_PAUSE_EN adds a pause input that freezes WAIT.
module invader_march_scheduler #(
   parameter int unsigned X_MIN            = 16,
   parameter int unsigned X_MAX            = 560,
   parameter int unsigned X_STEP           = 8,
   parameter int unsigned Y_START          = 32,
   parameter int unsigned Y_STEP           = 16,
   parameter int unsigned Y_LIMIT          = 400,
   parameter int unsigned PERIOD_MIN       = 200000,
   parameter int unsigned PERIOD_PER_ENEMY = 20000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [5:0]  alive,
`ifdef MARCH_PAUSE_EN
   input  logic        pause,
`endif
   output logic        mueva,
   output logic        dir,
   output logic [10:0] posx,
   output logic [9:0]  posy,
   output logic        busy,
   output logic        landed
);

   localparam int unsigned CNT_W = 24;
   localparam int unsigned X_W   = 11;
   localparam int unsigned Y_W   = 10;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WAIT   = 3'd1,
      S_STEP   = 3'd2,
      S_DROP   = 3'd3,
      S_LANDED = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [X_W-1:0]   posx_q, posx_d;
   logic [Y_W-1:0]   posy_q, posy_d;
   logic             dir_q, dir_d;
   logic             mueva_q, mueva_d;
   logic             busy_q, busy_d;
   logic             landed_q, landed_d;

   logic [CNT_W-1:0] period_c;
   logic             tick_c;
   logic             at_edge_c;
   logic             hold_c;

`ifdef MARCH_PAUSE_EN
   assign hold_c = pause;
`else
   assign hold_c = 1'b0;
`endif

   // Period follows alive live; comparing cnt+1 >= period avoids underflow of period-1.
   assign period_c = CNT_W'(PERIOD_MIN) + CNT_W'(alive) * CNT_W'(PERIOD_PER_ENEMY);
   assign tick_c   = ((CNT_W+1)'(cnt_q) + (CNT_W+1)'(1)) >= (CNT_W+1)'(period_c);

   assign at_edge_c = dir_q ? ((12'(posx_q) + 12'(X_STEP)) > 12'(X_MAX))
                            : (12'(posx_q) < 12'(X_MIN + X_STEP));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      posx_d  = posx_q;
      posy_d  = posy_q;
      dir_d   = dir_q;

      case (state_q)
         S_IDLE, S_LANDED: begin
            if (start) begin
               state_d = S_WAIT;
               cnt_d   = '0;
               posx_d  = X_W'(X_MIN);
               posy_d  = Y_W'(Y_START);
               dir_d   = 1'b1;
            end
         end
         S_WAIT: begin
            if (!hold_c) begin
               if (tick_c) begin
                  cnt_d = '0;
                  if (alive == 6'd0) begin
                     state_d = S_IDLE;
                  end else if (at_edge_c) begin
                     state_d = S_DROP;
                     posy_d  = posy_q + Y_W'(Y_STEP);
                     dir_d   = ~dir_q;
                  end else begin
                     state_d = S_STEP;
                     posx_d  = dir_q ? (posx_q + X_W'(X_STEP)) : (posx_q - X_W'(X_STEP));
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_STEP: state_d = S_WAIT;
         S_DROP: state_d = (posy_q >= Y_W'(Y_LIMIT)) ? S_LANDED : S_WAIT;
         default: state_d = S_IDLE;
      endcase

      // Outputs are the registered image of the state being entered.
      mueva_d  = (state_d == S_STEP) || (state_d == S_DROP);
      busy_d   = (state_d == S_WAIT) || (state_d == S_STEP) || (state_d == S_DROP);
      landed_d = (state_d == S_LANDED);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         posx_q   <= X_W'(X_MIN);
         posy_q   <= Y_W'(Y_START);
         dir_q    <= 1'b1;
         mueva_q  <= 1'b0;
         busy_q   <= 1'b0;
         landed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         posx_q   <= posx_d;
         posy_q   <= posy_d;
         dir_q    <= dir_d;
         mueva_q  <= mueva_d;
         busy_q   <= busy_d;
         landed_q <= landed_d;
      end
   end

   assign mueva  = mueva_q;
   assign dir    = dir_q;
   assign posx   = posx_q;
   assign posy   = posy_q;
   assign busy   = busy_q;
   assign landed = landed_q;

endmodule
